// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family: FSM state encoding and a
// constant-foldable ceil(log2) helper used to size bit counters.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/left_shift_piso_tx_bit_cnt.sv
// Bit counter for the PISO transmitter: loads the word width, counts beats
// down and never wraps below zero.
module piso_bit_cnt
    import shift_pkg::*;
#(
    parameter int DW    = 4,
    parameter int CNT_W = clog2(DW + 1)
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic load,
    input  logic dec,
    output logic last,
    output logic zero
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= CNT_W'(DW);
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign last = (cnt_reg == CNT_W'(1));
    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/left_shift_piso_tx.sv
// Parallel-in/serial-out transmitter, MSB first, valid/ready on both sides.
// Optional trailing even-parity beat when PISO_PARITY_EN is defined.
module left_shift_piso_tx
    import shift_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          fill_bit,
    output logic          sout,
    output logic          sout_valid,
    input  logic          sout_ready,
    output logic          done
);

    localparam int CNT_W = clog2(DW + 1);

    state_t        state_reg, state_next;
    logic [DW-1:0] shreg_reg, shreg_next;
    logic [DW-1:0] shifted;
    logic          done_reg, done_next;
    logic          cnt_last, cnt_zero;
    logic          beat, hs, last_beat, shift_beat;

    // Left shift with fill_bit entering at the LSB.
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = fill_bit;
            end else begin : g_upper
                assign shifted[gi] = shreg_reg[gi-1];
            end
        end
    endgenerate

    assign beat       = sout_valid & sout_ready;
    assign hs         = in_valid & in_ready;
    assign shift_beat = (state_reg == ST_SHIFT) & beat;
    assign last_beat  = shift_beat & cnt_last;

    piso_bit_cnt #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk      (clk),
        .sync_rst (sync_rst),
        .load     (hs),
        .dec      (shift_beat & ~cnt_zero),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

`ifdef PISO_PARITY_EN
    logic par_reg;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            par_reg <= 1'b0;
        end else if (hs) begin
            par_reg <= 1'b0;
        end else if (shift_beat) begin
            par_reg <= par_reg ^ shreg_reg[DW-1];
        end
    end

    // The back-to-back reload point is the parity beat, not the last data beat.
    assign in_ready   = ~sync_rst & ((state_reg == ST_IDLE) |
                                     ((state_reg == ST_PAR) & sout_ready));
    assign sout_valid = (state_reg == ST_SHIFT) | (state_reg == ST_PAR);
    assign sout       = (state_reg == ST_SHIFT) ? shreg_reg[DW-1] :
                        (state_reg == ST_PAR)   ? par_reg : 1'b0;
`else
    assign in_ready   = ~sync_rst & ((state_reg == ST_IDLE) |
                                     ((state_reg == ST_SHIFT) & cnt_last & sout_ready));
    assign sout_valid = (state_reg == ST_SHIFT);
    assign sout       = (state_reg == ST_SHIFT) ? shreg_reg[DW-1] : 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (hs) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (beat) shreg_next = shifted;
                if (last_beat) begin
`ifdef PISO_PARITY_EN
                    state_next = ST_PAR;
`else
                    done_next  = 1'b1;
                    state_next = hs ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PAR: begin
                if (beat) begin
                    done_next  = 1'b1;
                    state_next = hs ? ST_SHIFT : ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
        // A new word replaces whatever the final shift would have produced.
        if (hs) shreg_next = in_data;
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            done_reg  <= done_next;
        end
    end

    assign done = done_reg;

endmodule

// File: tb/tb_left_shift_piso_tx.sv
// Self-checking bench for left_shift_piso_tx (DW=4): directed scenarios plus a
// randomized run against a bit-queue reference model.
module tb_left_shift_piso_tx;

    localparam int DW = 4;
`ifdef PISO_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic          clk = 1'b0;
    logic          sync_rst, in_valid, fill_bit, sout_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, sout, sout_valid, done;

    int errors = 0;
    int checks = 0;

    // Reference model: bits still owed to the serial side, and the done prediction.
    bit q[$];
    bit exp_done = 1'b0;

    always #5 clk = ~clk;

    left_shift_piso_tx #(.DW(DW)) dut (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .fill_bit   (fill_bit),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .done       (done)
    );

    function automatic bit model_ready();
        return !sync_rst && (q.size() == 0 || (q.size() == 1 && sout_ready));
    endfunction

    function automatic bit model_sout();
        return (q.size() > 0) ? q[0] : 1'b0;
    endfunction

    task automatic drive(input bit r, input bit v, input logic [DW-1:0] d,
                         input bit s, input bit f);
        @(negedge clk);
        sync_rst   = r;
        in_valid   = v;
        in_data    = d;
        sout_ready = s;
        fill_bit   = f;
        #1;
    endtask

    task automatic tick();
        bit rdy;
        bit bt;
        rdy = model_ready();
        @(posedge clk);
        if (sync_rst) begin
            q.delete();
            exp_done = 1'b0;
        end else begin
            bt = (q.size() > 0) && sout_ready;
            exp_done = bt && (q.size() == 1);
            if (bt) void'(q.pop_front());
            if (in_valid && rdy) begin
                for (int b = DW - 1; b >= 0; b--) q.push_back(in_data[b]);
`ifdef PISO_PARITY_EN
                q.push_back(^in_data);
`endif
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 4'hA, 1, 0);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
            checks++; if (sout_valid !== 1'b0) begin errors++; $display("FAIL reset_sout_valid: got %b expected 0", sout_valid); end
            tick();
        end
        drive(0, 0, 4'h0, 1, 0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b expected 0", sout); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
        tick();
    endtask

    task automatic test_single();
        logic [NB-1:0] seq;
`ifdef PISO_PARITY_EN
        seq = {4'b1011, 1'b1};
`else
        seq = 4'b1011;
`endif
        drive(0, 1, 4'b1011, 1, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %b expected 1", in_ready); end
        tick();
        for (int i = 0; i < NB; i++) begin
            drive(0, 0, 4'h0, 1, 0);
            checks++; if (sout_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, sout_valid); end
            checks++; if (sout !== seq[NB-1-i]) begin errors++; $display("FAIL single_bit[%0d]: got %b expected %b", i, sout, seq[NB-1-i]); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_early_done[%0d]: got %b expected 0", i, done); end
            tick();
        end
        drive(0, 0, 4'h0, 1, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", done); end
        checks++; if (sout_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", sout_valid); end
        tick();
        drive(0, 0, 4'h0, 1, 0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", done); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [NB-1:0] seq;
`ifdef PISO_PARITY_EN
        seq = {4'b1100, 1'b0};
`else
        seq = 4'b1100;
`endif
        drive(0, 1, 4'b1100, 1, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'b0011, 0, 1);
            checks++; if (sout !== 1'b1 || sout_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%b expected 1/1", i, sout, sout_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            tick();
        end
        for (int i = 0; i < NB; i++) begin
            drive(0, 0, 4'h0, 1, 1);
            checks++; if (sout !== seq[NB-1-i]) begin errors++; $display("FAIL bp_bit[%0d]: got %b expected %b", i, sout, seq[NB-1-i]); end
            tick();
        end
        drive(0, 0, 4'h0, 1, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done); end
        tick();
    endtask

    task automatic test_back_to_back();
        bit exp_bits[$];
        int dones;
        logic [DW-1:0] w0, w1;
        w0 = 4'b1001;
        w1 = 4'b0110;
        for (int b = DW - 1; b >= 0; b--) exp_bits.push_back(w0[b]);
`ifdef PISO_PARITY_EN
        exp_bits.push_back(^w0);
`endif
        for (int b = DW - 1; b >= 0; b--) exp_bits.push_back(w1[b]);
`ifdef PISO_PARITY_EN
        exp_bits.push_back(^w1);
`endif
        dones = 0;
        drive(0, 1, w0, 1, 0);
        tick();
        for (int i = 0; i < 2 * NB; i++) begin
            drive(0, (i < NB) ? 1'b1 : 1'b0, w1, 1, 0);
            if (i == NB - 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_reload_ready: got %b expected 1", in_ready); end
            end
            checks++; if (sout_valid !== 1'b1 || sout !== exp_bits[i]) begin errors++; $display("FAIL b2b_beat[%0d]: got %b/%b expected 1/%b", i, sout_valid, sout, exp_bits[i]); end
            if (done === 1'b1) dones++;
            tick();
        end
        drive(0, 0, 4'h0, 1, 0);
        if (done === 1'b1) dones++;
        checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dones); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 4'b1111, 1, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 4'h0, 1, 0);
            tick();
        end
        drive(1, 1, 4'b0000, 1, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", in_ready); end
        tick();
        drive(0, 1, 4'b0101, 1, 0);
        checks++; if (sout_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_flush: got %b/%b expected 0/0", sout_valid, done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_accept: got %b expected 1", in_ready); end
        tick();
        for (int i = 0; i < DW; i++) begin
            drive(0, 0, 4'h0, 1, 0);
            checks++; if (sout !== ((i % 2) == 1) || done !== 1'b0) begin errors++; $display("FAIL mid_rst_next[%0d]: got %b/%b expected %b/0", i, sout, done, (i % 2) == 1); end
            tick();
        end
        for (int i = DW; i < NB + 1; i++) begin
            drive(0, 0, 4'h0, 1, 0);
            tick();
        end
    endtask

    task automatic test_random();
        bit r, v, s, f;
        logic [DW-1:0] d;
        drive(1, 0, 4'h0, 0, 0);
        tick();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) != 0);
            f = $urandom_range(0, 1);
            d = DW'($urandom);
            drive(r, v, d, s, f);
            checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, model_ready()); end
            checks++; if (sout_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_sout_valid[%0d]: got %b expected %b", i, sout_valid, q.size() > 0); end
            checks++; if (sout !== model_sout()) begin errors++; $display("FAIL rnd_sout[%0d]: got %b expected %b", i, sout, model_sout()); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL rnd_done[%0d]: got %b expected %b", i, done, exp_done); end
            $display("cycle %0d rst=%b vld=%b data=%h srdy=%b -> rdy=%b sv=%b sout=%b done=%b", i, r, v, d, s, in_ready, sout_valid, sout, done);
            tick();
        end
    endtask

    initial begin
        sync_rst   = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        fill_bit   = 1'b0;
        sout_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
